ps2_receiver: RTL and testbench

PS/2 device-to-host receiver and receive FIFO. It sits directly upstream of the keyboard scancode decoder. It samples the raw `ps2_clk`/`ps2_data` lines in the system clock domain, deframes 11-bit PS/2 frames and checks them. Good bytes are buffered in a small FIFO and presented through the `ready`/`data`/`nextdata_n` handshake that the decoder consumes.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_fifo.sv | 52 +++++
 rtl/ps2_receiver.sv | 103 ++++++++++
 tb/tb_ps2_receiver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 receive path.
//   PS2_FRAME_BITS : bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_START      : required start-bit value
//   PS2_STOP       : required stop-bit value
//   PS2_FIFO_DEPTH : default receive FIFO depth
//   clog2()        : ceiling log2, used for pointer and counter widths
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic        PS2_START      = 1'b0;
  localparam logic        PS2_STOP       = 1'b1;
  localparam int unsigned PS2_FIFO_DEPTH = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous byte FIFO for received PS/2 scancodes.
//   clk, clrn : clock, asynchronous active-high reset
//   push, din : write request and byte; ignored when full unless a pop occurs too
//   pop       : read request; ignored when empty
//   dout      : byte at the head (valid while !empty)
//   empty/full: occupancy status
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = PS2_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_en, rd_en;

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    rd_en = pop && !empty;
    // A pop in the same cycle frees the slot being written when full.
    wr_en = push && (!full || rd_en);
    dout  = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (wr_en) begin
        mem_q[wptr_q[AW-1:0]] <= din;
        wptr_q <= wptr_q + 1'b1;
      end
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver with receive FIFO.
//   clk, clrn   : system clock, asynchronous active-high reset
//   ps2_clk/data: raw asynchronous PS/2 lines
//   nextdata_n  : active-low level-sensitive pop request
//   data, ready : FIFO head byte and non-empty flag
//   overflow    : sticky, good frame dropped on a full FIFO
//   frame_err   : sticky, frame dropped for bad start/stop/parity
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = PS2_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned IdleW = clog2(TIMEOUT_CYC + 1);

  logic [2:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             fall_q;
  logic [3:0]       bcnt_q;
  logic [9:0]       shift_q;
  logic [IdleW-1:0] idle_q;
  logic             overflow_q, frame_err_q;

  logic bit_in, frame_last, frame_good, push_req, pop, empty, full;

  always_comb begin
    bit_in     = data_sync_q[1];
    frame_last = fall_q && (bcnt_q == 4'(PS2_FRAME_BITS - 1));
    // shift_q[0] is the start bit, [8:1] data LSB first, [9] parity.
    frame_good = (shift_q[0] == PS2_START) && (bit_in == PS2_STOP) && (^shift_q[9:1]);
    push_req   = frame_last && frame_good;
    pop        = !nextdata_n && !empty;
    ready      = !empty;
    overflow   = overflow_q;
    frame_err  = frame_err_q;
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      fall_q      <= 1'b0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      idle_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      // Registered edge strobe; the data bit is taken on the cycle it is high.
      fall_q      <= clk_sync_q[2] & ~clk_sync_q[1];

      if (fall_q) begin
        idle_q <= '0;
        if (frame_last) begin
          bcnt_q <= '0;
          if (!frame_good) frame_err_q <= 1'b1;
        end else begin
          bcnt_q  <= bcnt_q + 4'd1;
          shift_q <= {bit_in, shift_q[9:1]};
        end
      end else if (bcnt_q != '0) begin
        // Stalled partial frame: drop it silently.
        if (idle_q == IdleW'(TIMEOUT_CYC)) begin
          bcnt_q <= '0;
          idle_q <= '0;
        end else begin
          idle_q <= idle_q + IdleW'(1);
        end
      end else begin
        idle_q <= '0;
      end

      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  ps2_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .clrn (clrn),
    .push (push_req),
    .pop  (pop),
    .din  (shift_q[8:1]),
    .dout (data),
    .empty(empty),
    .full (full)
  );

endmodule

// File: tb/tb_ps2_receiver.sv
module tb_ps2_receiver;

  localparam int Half = 10;  // clk cycles per PS/2 clock phase

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  int tests = 0;
  int fails = 0;

  ps2_receiver #(
    .FIFO_DEPTH (8),
    .TIMEOUT_CYC(200)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic flip,
                                             input logic stop);
    return {stop, (~^d) ^ flip, d, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (Half) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (Half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Drives the bit and leaves ps2_clk low right after its falling edge.
  task automatic ps2_last_fall(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (Half) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic ps2_release();
    repeat (Half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                            input int nbits);
    logic [10:0] f;
    f = frame_bits(d, flip, stop);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
  endtask

  task automatic pop_one();
    @(negedge clk) nextdata_n = 1'b0;
    @(negedge clk) nextdata_n = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_bit(tag, ready, 1'b1);
    check_byte(tag, data, exp);
    pop_one();
  endtask

  task automatic do_reset();
    @(negedge clk) clrn = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_bit("rst_ready", ready, 1'b0);
    check_byte("rst_data", data, 8'h00);
    check_bit("rst_overflow", overflow, 1'b0);
    check_bit("rst_frame_err", frame_err, 1'b0);
    clrn = 1'b0;
    repeat (3) @(negedge clk);

    // Single good frame with exact push latency
    send_frame(8'h1C, 1'b0, 1'b1, 10);
    ps2_last_fall(1'b1);
    repeat (3) @(posedge clk);
    #1 check_bit("lat_ready_3", ready, 1'b0);
    @(posedge clk);
    #1 check_bit("lat_ready_4", ready, 1'b1);
    check_byte("lat_data", data, 8'h1C);
    ps2_release();
    pop_one();
    check_bit("single_pop_ready", ready, 1'b0);

    // Key sequence, then level-sensitive drain with no underflow
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check_byte("seq_head", data, 8'h1C);
    @(negedge clk) nextdata_n = 1'b0;
    @(posedge clk);
    #1 check_byte("seq_second", data, 8'hF0);
    @(posedge clk);
    #1 check_byte("seq_third", data, 8'h1C);
    check_bit("seq_third_ready", ready, 1'b1);
    @(posedge clk);
    #1 check_bit("seq_empty", ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 check_bit("seq_still_empty", ready, 1'b0);
    @(negedge clk) nextdata_n = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("seq_after_drain", ready, 1'b0);
    check_bit("seq_no_err", frame_err, 1'b0);

    // Bad parity
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    check_bit("par_ready", ready, 1'b0);
    check_bit("par_frame_err", frame_err, 1'b1);
    // Bad stop, from a clean reset so the flag is freshly set
    do_reset();
    check_bit("stop_pre_err", frame_err, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check_bit("stop_ready", ready, 1'b0);
    check_bit("stop_frame_err", frame_err, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1, 11);
    pop_check("after_bad_29", 8'h29);
    check_bit("after_bad_empty", ready, 1'b0);

    // Overflow: 9 frames into an 8-deep FIFO
    do_reset();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 11);
    check_bit("ovf_set", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) pop_check("ovf_read", 8'(i));
    check_bit("ovf_drained", ready, 1'b0);

    // Ninth push coincides with a pop: accepted, no overflow
    do_reset();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 11);
    send_frame(8'h09, 1'b0, 1'b1, 10);
    ps2_last_fall(1'b1);
    repeat (3) @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk) nextdata_n = 1'b1;
    ps2_release();
    check_bit("ovf_pop_clear", overflow, 1'b0);
    for (int i = 2; i <= 9; i++) pop_check("ovf_pop_read", 8'(i));
    check_bit("ovf_pop_drained", ready, 1'b0);

    // Timeout discards a partial frame silently
    do_reset();
    send_frame(8'h5A, 1'b0, 1'b1, 5);
    repeat (250) @(negedge clk);
    check_bit("to_idle_ready", ready, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 11);
    check_byte("to_data", data, 8'h5A);
    check_bit("to_frame_err", frame_err, 1'b0);
    check_bit("to_overflow", overflow, 1'b0);
    pop_one();
    check_bit("to_empty", ready, 1'b0);

    // Reset mid-frame with entries queued and a sticky flag set
    do_reset();
    send_frame(8'h00, 1'b1, 1'b1, 11);
    send_frame(8'h11, 1'b0, 1'b1, 11);
    send_frame(8'h22, 1'b0, 1'b1, 11);
    send_frame(8'h33, 1'b0, 1'b1, 11);
    check_byte("mid_pre_data", data, 8'h11);
    check_bit("mid_pre_err", frame_err, 1'b1);
    send_frame(8'h44, 1'b0, 1'b1, 4);
    @(negedge clk) clrn = 1'b1;
    #1;
    check_bit("mid_ready", ready, 1'b0);
    check_byte("mid_data", data, 8'h00);
    check_bit("mid_overflow", overflow, 1'b0);
    check_bit("mid_frame_err", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    send_frame(8'h66, 1'b0, 1'b1, 11);
    check_byte("post_rst_data", data, 8'h66);
    check_bit("post_rst_ready", ready, 1'b1);
    check_bit("post_rst_err", frame_err, 1'b0);
    pop_one();
    check_bit("post_rst_empty", ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
